// File: rtl/bomb_sequencer.sv
// Per-bomb lifecycle controller: fuse count, snapshot of blast cells, fire writes, restore writes.
// Latency: bomb_state follows bomb_check one frame_clk edge later; all outputs are registered.
// Backpressure: none; the map write port accepts one write per cycle and the placer reacts to bomb_state.
module bomb_sequencer #(
   parameter int         FUSE_FRAMES    = 120,
   parameter int         EXPLODE_SETTLE = 2,
   parameter int         BLAST_FRAMES   = 30,
   parameter logic [3:0] FIRE_TILE      = 4'd5,
   parameter logic [3:0] BRICK_TILE     = 4'd2,
   parameter logic [3:0] FLOOR_TILE     = 4'd0,
   parameter int         MAP_CELLS      = 300
) (
   input  logic            frame_clk,
   input  logic            Reset,
   input  logic            bomb_check,
   input  logic [4:0][9:0] explode_addr,
   input  logic [4:0]      explode_flag,
   input  logic [4:0][3:0] explode_data,
   output logic [3:0]      bomb_state,
   output logic [9:0]      map_addr,
   output logic [3:0]      map_data,
   output logic            map_wren,
   output logic            blast_active
);

   // Phase codes seen by the placer.
   localparam logic [3:0] CODE_IDLE    = 4'b0000;
   localparam logic [3:0] CODE_FUSE    = 4'b0010;
   localparam logic [3:0] CODE_EXPLODE = 4'b0001;
   localparam logic [3:0] CODE_WRITE   = 4'b0100;
   localparam logic [3:0] CODE_BLAST   = 4'b1000;
   localparam logic [3:0] CODE_CLEAR   = 4'b0011;
   localparam logic [3:0] CODE_DONE    = 4'b1111;

   // Terminal counts for the 10-bit phase counter.
   localparam logic [9:0] FUSE_LAST    = 10'(FUSE_FRAMES - 1);
   localparam logic [9:0] SETTLE_LAST  = 10'(EXPLODE_SETTLE - 1);
   localparam logic [9:0] BLAST_LAST   = 10'(BLAST_FRAMES - 1);
   localparam logic [9:0] CELLS_LIMIT  = 10'(MAP_CELLS);
   localparam logic [2:0] LAST_IDX     = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FUSE,
      S_EXPLODE,
      S_WRITE,
      S_BLAST,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t          state;
   logic [9:0]      cnt;
   logic [2:0]      idx;

   // Blast cells frozen at the end of EXPLODE; the placer may change its inputs afterwards.
   logic [4:0][9:0] snap_addr;
   logic [4:0]      snap_flag;
   logic [4:0][3:0] snap_data;

   // Entry that the next edge will put on the write port.
   logic [2:0]      sel_idx;
   logic [9:0]      ent_addr;
   logic            ent_flag;
   logic [3:0]      ent_data;
   logic            ent_ok;
   logic [3:0]      ent_restore;

   // Pick the entry for the upcoming write cycle. Leaving EXPLODE the snapshot is not yet
   // loaded, so entry 0 comes straight from the inputs being captured on that same edge.
   always_comb begin
      sel_idx  = 3'd0;
      ent_addr = snap_addr[0];
      ent_flag = snap_flag[0];
      ent_data = snap_data[0];
      if ((state == S_WRITE || state == S_CLEAR) && idx != LAST_IDX) begin
         sel_idx = idx + 3'd1;
      end
      if (state == S_EXPLODE) begin
         ent_addr = explode_addr[0];
         ent_flag = explode_flag[0];
         ent_data = explode_data[0];
      end else begin
         case (sel_idx)
            3'd1: begin
               ent_addr = snap_addr[1];
               ent_flag = snap_flag[1];
               ent_data = snap_data[1];
            end
            3'd2: begin
               ent_addr = snap_addr[2];
               ent_flag = snap_flag[2];
               ent_data = snap_data[2];
            end
            3'd3: begin
               ent_addr = snap_addr[3];
               ent_flag = snap_flag[3];
               ent_data = snap_data[3];
            end
            3'd4: begin
               ent_addr = snap_addr[4];
               ent_flag = snap_flag[4];
               ent_data = snap_data[4];
            end
            default: begin
               ent_addr = snap_addr[0];
               ent_flag = snap_flag[0];
               ent_data = snap_data[0];
            end
         endcase
      end
      // Off-map addresses are never written, neither as fire nor as restore.
      ent_ok      = ent_flag && (ent_addr < CELLS_LIMIT);
      // Bricks caught in the blast are destroyed and come back as floor.
      ent_restore = (ent_data == BRICK_TILE) ? FLOOR_TILE : ent_data;
   end

   // Lifecycle FSM with registered phase code, write port and blast flag.
   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state        <= S_IDLE;
         cnt          <= 10'd0;
         idx          <= 3'd0;
         snap_addr    <= '0;
         snap_flag    <= '0;
         snap_data    <= '0;
         bomb_state   <= CODE_IDLE;
         map_addr     <= 10'd0;
         map_data     <= 4'd0;
         map_wren     <= 1'b0;
         blast_active <= 1'b0;
      end else begin
         map_wren <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bomb_check) begin
                  state      <= S_FUSE;
                  bomb_state <= CODE_FUSE;
                  cnt        <= 10'd0;
               end
            end

            S_FUSE: begin
               if (!bomb_check) begin
                  // Bomb withdrawn before it went off: nothing touched the map.
                  state      <= S_IDLE;
                  bomb_state <= CODE_IDLE;
                  cnt        <= 10'd0;
               end else if (cnt == FUSE_LAST) begin
                  state      <= S_EXPLODE;
                  bomb_state <= CODE_EXPLODE;
                  cnt        <= 10'd0;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end

            S_EXPLODE: begin
               if (cnt == SETTLE_LAST) begin
                  snap_addr    <= explode_addr;
                  snap_flag    <= explode_flag;
                  snap_data    <= explode_data;
                  state        <= S_WRITE;
                  bomb_state   <= CODE_WRITE;
                  blast_active <= 1'b1;
                  cnt          <= 10'd0;
                  idx          <= 3'd0;
                  map_addr     <= ent_addr;
                  map_data     <= FIRE_TILE;
                  map_wren     <= ent_ok;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end

            S_WRITE: begin
               if (idx == LAST_IDX) begin
                  state      <= S_BLAST;
                  bomb_state <= CODE_BLAST;
                  cnt        <= 10'd0;
               end else begin
                  idx      <= idx + 3'd1;
                  map_addr <= ent_addr;
                  map_data <= FIRE_TILE;
                  map_wren <= ent_ok;
               end
            end

            S_BLAST: begin
               if (cnt == BLAST_LAST) begin
                  state      <= S_CLEAR;
                  bomb_state <= CODE_CLEAR;
                  cnt        <= 10'd0;
                  idx        <= 3'd0;
                  map_addr   <= ent_addr;
                  map_data   <= ent_restore;
                  map_wren   <= ent_ok;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end

            S_CLEAR: begin
               if (idx == LAST_IDX) begin
                  state        <= S_DONE;
                  bomb_state   <= CODE_DONE;
                  blast_active <= 1'b0;
                  idx          <= 3'd0;
               end else begin
                  idx      <= idx + 3'd1;
                  map_addr <= ent_addr;
                  map_data <= ent_restore;
                  map_wren <= ent_ok;
               end
            end

            S_DONE: begin
               // Held until the placer acknowledges by dropping bomb_check.
               if (!bomb_check) begin
                  state      <= S_IDLE;
                  bomb_state <= CODE_IDLE;
               end
            end

            default: begin
               state        <= S_IDLE;
               bomb_state   <= CODE_IDLE;
               blast_active <= 1'b0;
               cnt          <= 10'd0;
               idx          <= 3'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bomb_sequencer.sv
// Directed bench for bomb_sequencer with short fuse/settle/blast counts.
// Latency: one record per frame_clk cycle; outputs sampled on the falling edge.
// Backpressure: none; bomb_check is driven from the record tables.
module tb_bomb_sequencer;

   logic            frame_clk;
   logic            Reset;
   logic            bomb_check;
   logic [4:0][9:0] explode_addr;
   logic [4:0]      explode_flag;
   logic [4:0][3:0] explode_data;
   logic [3:0]      bomb_state;
   logic [9:0]      map_addr;
   logic [3:0]      map_data;
   logic            map_wren;
   logic            blast_active;

   int checks   = 0;
   int failures = 0;

   bomb_sequencer #(
      .FUSE_FRAMES   (4),
      .EXPLODE_SETTLE(2),
      .BLAST_FRAMES  (3)
   ) dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .bomb_check  (bomb_check),
      .explode_addr(explode_addr),
      .explode_flag(explode_flag),
      .explode_data(explode_data),
      .bomb_state  (bomb_state),
      .map_addr    (map_addr),
      .map_data    (map_data),
      .map_wren    (map_wren),
      .blast_active(blast_active)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   typedef struct {
      logic       chk;
      logic [3:0] st;
      logic       wren;
      logic [9:0] addr;
      logic [3:0] data;
      logic       blast;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic chk, input logic [3:0] st, input logic wren,
                      input logic [9:0] a, input logic [3:0] d, input logic bl);
      vec_t v;
      v.chk = chk; v.st = st; v.wren = wren; v.addr = a; v.data = d; v.blast = bl;
      tbl.push_back(v);
   endtask

   task automatic add_rep(input int n, input logic chk, input logic [3:0] st, input logic bl);
      for (int i = 0; i < n; i++) add(chk, st, 1'b0, 10'd0, 4'd0, bl);
   endtask

   // Apply the first n records (all if n<0); called from a falling edge.
   task automatic run_tbl(input string name, input int n);
      int lim;
      lim = (n < 0 || n > tbl.size()) ? tbl.size() : n;
      for (int i = 0; i < lim; i++) begin
         bomb_check = tbl[i].chk;
         @(posedge frame_clk);
         @(negedge frame_clk);
         check($sformatf("%s[%0d].state", name, i), 32'(bomb_state), 32'(tbl[i].st));
         check($sformatf("%s[%0d].wren", name, i), 32'(map_wren), 32'(tbl[i].wren));
         check($sformatf("%s[%0d].blast", name, i), 32'(blast_active), 32'(tbl[i].blast));
         if (tbl[i].wren) begin
            check($sformatf("%s[%0d].addr", name, i), 32'(map_addr), 32'(tbl[i].addr));
            check($sformatf("%s[%0d].data", name, i), 32'(map_data), 32'(tbl[i].data));
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, ".state"}, 32'(bomb_state), 32'd0);
      check({name, ".wren"},  32'(map_wren), 32'd0);
      check({name, ".addr"},  32'(map_addr), 32'd0);
      check({name, ".data"},  32'(map_data), 32'd0);
      check({name, ".blast"}, 32'(blast_active), 32'd0);
   endtask

   // Full lifecycle: addr {45,44,46,25,65}, all flags, data {0,2,0,1,0}.
   task automatic build_a();
      tbl.delete();
      add_rep(4, 1'b1, 4'b0010, 1'b0);
      add_rep(2, 1'b1, 4'b0001, 1'b0);
      add(1'b1, 4'b0100, 1'b1, 10'd45, 4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd44, 4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd46, 4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd25, 4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd65, 4'd5, 1'b1);
      add_rep(3, 1'b1, 4'b1000, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd45, 4'd0, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd44, 4'd0, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd46, 4'd0, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd25, 4'd1, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd65, 4'd0, 1'b1);
      add_rep(3, 1'b1, 4'b1111, 1'b0);
      add_rep(2, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic set_a_inputs();
      explode_addr[0] = 10'd45; explode_addr[1] = 10'd44; explode_addr[2] = 10'd46;
      explode_addr[3] = 10'd25; explode_addr[4] = 10'd65;
      explode_flag    = 5'b11111;
      explode_data[0] = 4'd0; explode_data[1] = 4'd2; explode_data[2] = 4'd0;
      explode_data[3] = 4'd1; explode_data[4] = 4'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset        = 1'b0;
      bomb_check   = 1'b0;
      explode_addr = '0;
      explode_flag = '0;
      explode_data = '0;

      @(negedge frame_clk);
      @(negedge frame_clk);
      check_reset_outputs("reset");
      Reset = 1'b1;
      @(negedge frame_clk);
      check("idle_after_reset.state", 32'(bomb_state), 32'd0);

      // A: complete lifecycle with brick restore.
      set_a_inputs();
      build_a();
      run_tbl("seqA", -1);

      // B: flags {1,0,1,0,0}; bomb_check drops after FUSE and must not abort.
      explode_flag    = 5'b00101;
      explode_data[0] = 4'd2; explode_data[1] = 4'd0; explode_data[2] = 4'd7;
      explode_data[3] = 4'd0; explode_data[4] = 4'd0;
      tbl.delete();
      add_rep(4, 1'b1, 4'b0010, 1'b0);
      add_rep(1, 1'b1, 4'b0001, 1'b0);
      add_rep(1, 1'b0, 4'b0001, 1'b0);
      add(1'b0, 4'b0100, 1'b1, 10'd45, 4'd5, 1'b1);
      add(1'b0, 4'b0100, 1'b0, 10'd0,  4'd0, 1'b1);
      add(1'b0, 4'b0100, 1'b1, 10'd46, 4'd5, 1'b1);
      add(1'b0, 4'b0100, 1'b0, 10'd0,  4'd0, 1'b1);
      add(1'b0, 4'b0100, 1'b0, 10'd0,  4'd0, 1'b1);
      add_rep(3, 1'b0, 4'b1000, 1'b1);
      add(1'b0, 4'b0011, 1'b1, 10'd45, 4'd0, 1'b1);
      add(1'b0, 4'b0011, 1'b0, 10'd0,  4'd0, 1'b1);
      add(1'b0, 4'b0011, 1'b1, 10'd46, 4'd7, 1'b1);
      add(1'b0, 4'b0011, 1'b0, 10'd0,  4'd0, 1'b1);
      add(1'b0, 4'b0011, 1'b0, 10'd0,  4'd0, 1'b1);
      add(1'b0, 4'b1111, 1'b0, 10'd0,  4'd0, 1'b0);
      add(1'b0, 4'b0000, 1'b0, 10'd0,  4'd0, 1'b0);
      run_tbl("seqB", -1);

      // C: index 4 points off the map (310) and is never written.
      explode_addr[0] = 10'd100; explode_addr[1] = 10'd99; explode_addr[2] = 10'd101;
      explode_addr[3] = 10'd80;  explode_addr[4] = 10'd310;
      explode_flag    = 5'b11111;
      explode_data[0] = 4'd1; explode_data[1] = 4'd2; explode_data[2] = 4'd3;
      explode_data[3] = 4'd2; explode_data[4] = 4'd4;
      tbl.delete();
      add_rep(4, 1'b1, 4'b0010, 1'b0);
      add_rep(2, 1'b1, 4'b0001, 1'b0);
      add(1'b1, 4'b0100, 1'b1, 10'd100, 4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd99,  4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd101, 4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b1, 10'd80,  4'd5, 1'b1);
      add(1'b1, 4'b0100, 1'b0, 10'd0,   4'd0, 1'b1);
      add_rep(3, 1'b1, 4'b1000, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd100, 4'd1, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd99,  4'd0, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd101, 4'd3, 1'b1);
      add(1'b1, 4'b0011, 1'b1, 10'd80,  4'd0, 1'b1);
      add(1'b1, 4'b0011, 1'b0, 10'd0,   4'd0, 1'b1);
      add(1'b1, 4'b1111, 1'b0, 10'd0,   4'd0, 1'b0);
      add(1'b0, 4'b0000, 1'b0, 10'd0,   4'd0, 1'b0);
      run_tbl("seqC", -1);

      // D: bomb_check drops in FUSE cycle 2 -> back to IDLE, no writes.
      tbl.delete();
      add_rep(3, 1'b1, 4'b0010, 1'b0);
      add_rep(4, 1'b0, 4'b0000, 1'b0);
      run_tbl("abort", -1);

      // E: reset pulled during WRITE index 2, then a full restart.
      set_a_inputs();
      build_a();
      run_tbl("preRst", 9);
      Reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(posedge frame_clk);
      @(negedge frame_clk);
      check_reset_outputs("held_rst");
      Reset = 1'b1;
      run_tbl("restart", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
